// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module   : alu_seq_pkg
//  Brief    : Opcodes, state encoding and helpers shared by the ALU sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam logic [3:0] OP_MOD = 4'b0110;

   localparam int ERR_OVF = 0;
   localparam int ERR_DZE = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } seq_state_e;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
             (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_settle_timer.sv
// ============================================================================
//  Module   : alu_seq_settle_timer
//  Brief    : Loadable down-counter with a zero flag for the settle window.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_settle_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Brief    : Clocked command/response front-end for the combinational ALU
//             breadboard, with a chaining accumulator.
//             Optional error counter output enabled by ALU_SEQ_ERR_COUNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic        cmd_use_acc,
   input  logic        acc_clear,
   output logic [15:0] alu_in1,
   output logic [15:0] alu_in2,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_out,
   input  logic [1:0]  alu_err,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_err,
   output logic        rsp_illegal,
`ifdef ALU_SEQ_ERR_COUNT_EN
   output logic [7:0]  err_count,
`endif
   output logic [31:0] acc
);

   localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   generate
      if (SETTLE_CYCLES < 1) begin : g_bad_settle
         $error("alu_cmd_sequencer: SETTLE_CYCLES must be at least 1");
      end
      if ((2 ** CNT_W) <= SETTLE_CYCLES) begin : g_bad_cnt_w
         $error("alu_cmd_sequencer: CNT_W too narrow for SETTLE_CYCLES");
      end
   endgenerate

   seq_state_e  state_q, state_d;
   logic [15:0] alu_in1_q, alu_in1_d;
   logic [15:0] alu_in2_q, alu_in2_d;
   logic [3:0]  alu_op_q, alu_op_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [1:0]  rsp_err_q, rsp_err_d;
   logic        rsp_illegal_q, rsp_illegal_d;
   logic [31:0] acc_q, acc_d;

   logic        tmr_load;
   logic        tmr_dec;
   logic        tmr_zero;
   logic        cap_has_err;

   alu_seq_settle_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (c_SETTLE_LOAD),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   assign cap_has_err = alu_err[ERR_OVF] | alu_err[ERR_DZE];

   always_comb begin
      state_d       = state_q;
      alu_in1_d     = alu_in1_q;
      alu_in2_d     = alu_in2_q;
      alu_op_d      = alu_op_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      rsp_illegal_d = rsp_illegal_q;
      acc_d         = acc_q;
      tmr_load      = 1'b0;
      tmr_dec       = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (is_legal_op(cmd_op)) begin
                  alu_in1_d = cmd_use_acc ? acc_q[15:0] : cmd_a;
                  alu_in2_d = cmd_b;
                  alu_op_d  = cmd_op;
                  tmr_load  = 1'b1;
                  state_d   = WAIT;
               end else begin
                  // Illegal ops never reach the breadboard; answer directly.
                  rsp_data_d    = '0;
                  rsp_err_d     = '0;
                  rsp_illegal_d = 1'b1;
                  rsp_valid_d   = 1'b1;
                  state_d       = RESP;
               end
            end
         end
         WAIT: begin
            if (tmr_zero) begin
               rsp_data_d    = alu_out;
               rsp_err_d     = alu_err;
               rsp_illegal_d = 1'b0;
               rsp_valid_d   = 1'b1;
               alu_op_d      = OP_NOP;
               if (!cap_has_err) begin
                  acc_d = alu_out;
               end
               state_d = RESP;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (acc_clear) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         alu_in1_q     <= '0;
         alu_in2_q     <= '0;
         alu_op_q      <= OP_NOP;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_err_q     <= '0;
         rsp_illegal_q <= 1'b0;
         acc_q         <= '0;
      end else begin
         state_q       <= state_d;
         alu_in1_q     <= alu_in1_d;
         alu_in2_q     <= alu_in2_d;
         alu_op_q      <= alu_op_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
         rsp_illegal_q <= rsp_illegal_d;
         acc_q         <= acc_d;
      end
   end

`ifdef ALU_SEQ_ERR_COUNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       err_evt;

   always_comb begin
      err_evt = ((state_q == WAIT) && tmr_zero && cap_has_err) ||
                ((state_q == IDLE) && cmd_valid && !is_legal_op(cmd_op));
      err_cnt_d = err_cnt_q;
      if (acc_clear) begin
         err_cnt_d = '0;
      end else if (err_evt && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

   assign cmd_ready   = (state_q == IDLE);
   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign alu_op      = alu_op_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_illegal = rsp_illegal_q;
   assign acc         = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
//  Module   : tb_alu_cmd_sequencer
//  Brief    : Self-checking bench: directed table, corner sequences, random.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

   localparam int SETTLE = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic        cmd_use_acc;
   logic        acc_clear;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic [3:0]  alu_op;
   logic [31:0] alu_out;
   logic [1:0]  alu_err;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_err;
   logic        rsp_illegal;
   logic [31:0] acc;
`ifdef ALU_SEQ_ERR_COUNT_EN
   logic [7:0]  err_count;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] acc_m;
   int          errcnt_m;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .CNT_W         (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_use_acc (cmd_use_acc),
      .acc_clear   (acc_clear),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_op      (alu_op),
      .alu_out     (alu_out),
      .alu_err     (alu_err),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .rsp_illegal (rsp_illegal),
`ifdef ALU_SEQ_ERR_COUNT_EN
      .err_count   (err_count),
`endif
      .acc         (acc)
   );

   // Breadboard behaviour: returns {err[1:0], out[31:0]}.
   function automatic logic [33:0] bb_eval(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
      logic [31:0] xx, yy, o;
      logic [1:0]  e;
      xx = {16'h0, x};
      yy = {16'h0, y};
      o  = 32'h0;
      e  = 2'b00;
      case (op)
         4'd2: begin o = xx + yy; e = (o > 32'hFFFF) ? 2'b01 : 2'b00; end
         4'd3: begin o = xx - yy; e = (x < y) ? 2'b01 : 2'b00; end
         4'd4: begin o = xx * yy; end
         4'd5: begin if (y == 0) e = 2'b10; else o = xx / yy; end
         4'd6: begin if (y == 0) e = 2'b10; else o = xx % yy; end
         default: begin o = 32'h0; end
      endcase
      return {e, o};
   endfunction

   always_comb {alu_err, alu_out} = bb_eval(alu_op, alu_in1, alu_in2);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic ua);
      int guard;
      guard = 0;
      @(negedge clk);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
      while (!cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("cmd_ready_at_issue", cmd_ready, 1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic ua, input int hold, input logic [31:0] ed, input logic [1:0] ee,
                          input logic ei, input logic [31:0] eacc, input int elat);
      int   lat;
      logic op_moved;
      send(op, a, b, ua);
      lat = 0;
      op_moved = (alu_op != 4'b0000);
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
         if (alu_op != 4'b0000) op_moved = 1'b1;
      end
      check({nm, ".latency"}, lat, elat);
      check({nm, ".rsp_data"}, rsp_data, ed);
      check({nm, ".rsp_err"}, {30'b0, rsp_err}, {30'b0, ee});
      check({nm, ".rsp_illegal"}, rsp_illegal, ei);
      check({nm, ".acc"}, acc, eacc);
      check({nm, ".alu_op_idle"}, alu_op, 0);
      check({nm, ".cmd_ready_busy"}, cmd_ready, 0);
      if (ei) check({nm, ".alu_op_untouched"}, op_moved, 0);
      if (ei || ee != 2'b00) errcnt_m = (errcnt_m >= 255) ? 255 : errcnt_m + 1;
`ifdef ALU_SEQ_ERR_COUNT_EN
      check({nm, ".err_count"}, err_count, errcnt_m);
`endif
      for (int i = 0; i < hold; i++) begin
         if (i == 0) begin
            cmd_op = 4'd2; cmd_a = 16'd1000; cmd_b = 16'd1000; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
         end
         @(negedge clk);
         cmd_valid = 1'b0;
         check({nm, ".hold_valid"}, rsp_valid, 1);
         check({nm, ".hold_data"}, rsp_data, ed);
         check({nm, ".hold_ready"}, cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({nm, ".released"}, rsp_valid, 0);
      check({nm, ".idle_after"}, cmd_ready, 1);
      acc_m = eacc;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        ua;
      int          hold;
      logic [31:0] ed;
      logic [1:0]  ee;
      logic        ei;
      logic [31:0] eacc;
      int          elat;
   } vec_t;

   vec_t vt[9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{4'd2,  16'd11,  16'd51,     1'b0, 0, 32'd62,        2'b00, 1'b0, 32'd62,    SETTLE};
      vt[1] = '{4'd3,  16'd11,  16'd51,     1'b0, 1, 32'hFFFFFFD8,  2'b01, 1'b0, 32'd62,    SETTLE};
      vt[2] = '{4'd5,  16'd11,  16'd0,      1'b0, 0, 32'd0,         2'b10, 1'b0, 32'd62,    SETTLE};
      vt[3] = '{4'd4,  16'd0,   16'd2,      1'b1, 0, 32'd124,       2'b00, 1'b0, 32'd124,   SETTLE};
      vt[4] = '{4'hF,  16'd5,   16'd6,      1'b0, 0, 32'd0,         2'b00, 1'b1, 32'd124,   0};
      vt[5] = '{4'd6,  16'd100, 16'd7,      1'b0, 3, 32'd2,         2'b00, 1'b0, 32'd2,     SETTLE};
      vt[6] = '{4'd2,  16'd0,   16'hFFFF,   1'b1, 0, 32'h00010001,  2'b01, 1'b0, 32'd2,     SETTLE};
      vt[7] = '{4'd4,  16'd300, 16'd300,    1'b0, 2, 32'd90000,     2'b00, 1'b0, 32'd90000, SETTLE};
      vt[8] = '{4'd3,  16'd0,   16'd464,    1'b1, 0, 32'd24000,     2'b00, 1'b0, 32'd24000, SETTLE};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0;
      cmd_use_acc = 1'b0; acc_clear = 1'b0; rsp_ready = 1'b0;
      acc_m = 32'd0; errcnt_m = 0;
      repeat (3) @(negedge clk);
      check("reset.cmd_ready", cmd_ready, 1);
      check("reset.rsp_valid", rsp_valid, 0);
      check("reset.acc", acc, 0);
      check("reset.alu_op", alu_op, 0);
      check("reset.alu_in1", alu_in1, 0);
      check("reset.rsp_data", rsp_data, 0);
      check("reset.rsp_illegal", rsp_illegal, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].ua, vt[i].hold,
                 vt[i].ed, vt[i].ee, vt[i].ei, vt[i].eacc, vt[i].elat);
      end

      // acc_clear landing on the capture edge wins over the update.
      send(4'd2, 16'd20, 16'd22, 1'b0);
      repeat (SETTLE - 1) @(negedge clk);
      acc_clear = 1'b1;
      @(negedge clk);
      acc_clear = 1'b0;
      check("clr_cap.rsp_valid", rsp_valid, 1);
      check("clr_cap.rsp_data", rsp_data, 42);
      check("clr_cap.acc", acc, 0);
      acc_m = 32'd0; errcnt_m = 0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset while the settle window is running drops the command.
      run_cmd("pre_rst", 4'd2, 16'd3, 16'd4, 1'b0, 0, 32'd7, 2'b00, 1'b0, 32'd7, SETTLE);
      send(4'd4, 16'd9, 16'd9, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_wait.cmd_ready", cmd_ready, 1);
      check("rst_wait.rsp_valid", rsp_valid, 0);
      check("rst_wait.acc", acc, 0);
      check("rst_wait.alu_op", alu_op, 0);
      acc_m = 32'd0; errcnt_m = 0;
      repeat (SETTLE + 2) @(negedge clk);
      check("rst_wait.no_late_rsp", rsp_valid, 0);

      // Randomised commands against the reference model.
      for (int k = 0; k < 150; k++) begin
         logic [3:0]  op;
         logic [15:0] a, b, opnd;
         logic        ua, legal;
         logic [33:0] r;
         logic [31:0] ed, eacc;
         logic [1:0]  ee;
         op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(2, 6));
         a  = 16'($urandom);
         b  = ($urandom_range(0, 5) == 0) ? 16'h0 :
              (($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom));
         ua = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
            acc_clear = 1'b1;
            @(negedge clk);
            acc_clear = 1'b0;
            acc_m = 32'd0; errcnt_m = 0;
         end
         legal = (op >= 4'd2) && (op <= 4'd6);
         opnd  = ua ? acc_m[15:0] : a;
         r     = bb_eval(op, opnd, b);
         ed    = legal ? r[31:0] : 32'd0;
         ee    = legal ? r[33:32] : 2'b00;
         eacc  = (legal && ee == 2'b00) ? ed : acc_m;
         run_cmd($sformatf("rnd%0d", k), op, a, b, ua, $urandom_range(0, 2),
                 ed, ee, !legal, eacc, legal ? SETTLE : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
